// File: rtl/inst_seq.sv
`default_nettype none
// ============================================================================
// Module   : inst_seq
// Purpose  : Instruction sequencer for the PE-array core. For each of the
//            LEN_KIJ kernel positions it loads weights from xmem into the
//            PE array, streams activations into L0, executes, and drains
//            the OFIFO into pmem, then raises a one-cycle done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high
//   start        in   1   one-cycle request to run all kernel passes (IDLE only)
//   w_ready      in   1   weights for the current kij are present at W_BASE
//   ofifo_valid  in   1   OFIFO holds a complete output row
//   inst         out  34  registered core instruction word
//   kij          out  4   index of the pass in progress
//   busy         out  1   high in every state except IDLE and DONE
//   done         out  1   one-cycle pulse when the last pass completes
// ============================================================================
module inst_seq #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_NIJ = 36,
    parameter int LEN_KIJ = 9,
    parameter int W_BASE  = 1024,
    parameter int GAP_LEN = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        w_ready,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic [3:0]  kij,
    output logic        busy,
    output logic        done
);

    // Phase counter wide enough for the longest timed state.
    localparam int c_T_W = $clog2(LEN_NIJ + ROW + 3 * COL + GAP_LEN + 2) + 1;

    // Last phase value of each timed state, and the ORD read count.
    localparam logic [c_T_W-1:0] c_WLD_LAST = c_T_W'(COL);
    localparam logic [c_T_W-1:0] c_PLD_LAST = c_T_W'(ROW + 2 * COL - 1);
    localparam logic [c_T_W-1:0] c_GAP_LAST = c_T_W'(GAP_LEN - 1);
    localparam logic [c_T_W-1:0] c_AWR_LAST = c_T_W'(LEN_NIJ - 1);
    localparam logic [c_T_W-1:0] c_EXE_LAST = c_T_W'(LEN_NIJ + ROW + COL - 1);
    localparam logic [c_T_W-1:0] c_ORD_CNT  = c_T_W'(LEN_NIJ);
    localparam logic [c_T_W-1:0] c_T_ONE    = c_T_W'(1);

    localparam logic [3:0]  c_KIJ_LAST = 4'(LEN_KIJ - 1);
    localparam logic [10:0] c_NIJ11    = 11'(LEN_NIJ);
    localparam logic [10:0] c_WBASE11  = 11'(W_BASE);

    // Quiescent word: both memories disabled (active-low enables high).
    localparam logic [33:0] c_IDLE_WORD = 34'h1_800C_0000;

    // Instruction word bit positions.
    localparam int c_B_CEN_PMEM = 32;
    localparam int c_B_WEN_PMEM = 31;
    localparam int c_B_CEN_XMEM = 19;
    localparam int c_B_OFIFO_RD = 6;
    localparam int c_B_IFIFO_WR = 5;
    localparam int c_B_IFIFO_RD = 4;
    localparam int c_B_L0_RD    = 3;
    localparam int c_B_L0_WR    = 2;
    localparam int c_B_EXECUTE  = 1;
    localparam int c_B_LOAD     = 0;

    // State encoding.
    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_WAIT_W = 4'd1;
    localparam logic [3:0] c_ST_WLD    = 4'd2;
    localparam logic [3:0] c_ST_PLOAD  = 4'd3;
    localparam logic [3:0] c_ST_GAP    = 4'd4;
    localparam logic [3:0] c_ST_AWR    = 4'd5;
    localparam logic [3:0] c_ST_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_GAP2   = 4'd7;
    localparam logic [3:0] c_ST_ORD    = 4'd8;
    localparam logic [3:0] c_ST_DONE   = 4'd9;

    logic [3:0]       r_state;
    logic [c_T_W-1:0] r_t;
    logic [3:0]       r_kij;
    logic [33:0]      r_inst;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_state_n;
    logic [c_T_W-1:0] w_t_n;
    logic [3:0]       w_kij_n;
    logic             w_ord_rd;    // next cycle issues an OFIFO->pmem read
    logic [c_T_W-1:0] w_ord_idx;   // row offset of that read within the pass
    logic [10:0]      w_pbase;
    logic [33:0]      w_inst_n;

    // ------------------------------------------------------------------------
    // Next-state logic. In ORD, r_t counts reads already issued (including the
    // one shown in the current cycle), so it only advances when ofifo_valid is
    // sampled high; a low ofifo_valid stalls without losing an address.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_t_n     = r_t;
        w_kij_n   = r_kij;
        w_ord_rd  = 1'b0;
        w_ord_idx = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_n = c_ST_WAIT_W;
                    w_t_n     = '0;
                    w_kij_n   = 4'd0;
                end
            end
            c_ST_WAIT_W: begin
                if (w_ready) begin
                    w_state_n = c_ST_WLD;
                    w_t_n     = '0;
                end
            end
            c_ST_WLD: begin
                if (r_t == c_WLD_LAST) begin
                    w_state_n = c_ST_PLOAD;
                    w_t_n     = '0;
                end else begin
                    w_t_n = r_t + c_T_ONE;
                end
            end
            c_ST_PLOAD: begin
                if (r_t == c_PLD_LAST) begin
                    w_state_n = c_ST_GAP;
                    w_t_n     = '0;
                end else begin
                    w_t_n = r_t + c_T_ONE;
                end
            end
            c_ST_GAP: begin
                if (r_t == c_GAP_LAST) begin
                    w_state_n = c_ST_AWR;
                    w_t_n     = '0;
                end else begin
                    w_t_n = r_t + c_T_ONE;
                end
            end
            c_ST_AWR: begin
                if (r_t == c_AWR_LAST) begin
                    w_state_n = c_ST_EXEC;
                    w_t_n     = '0;
                end else begin
                    w_t_n = r_t + c_T_ONE;
                end
            end
            c_ST_EXEC: begin
                if (r_t == c_EXE_LAST) begin
                    w_state_n = c_ST_GAP2;
                    w_t_n     = '0;
                end else begin
                    w_t_n = r_t + c_T_ONE;
                end
            end
            c_ST_GAP2: begin
                w_state_n = c_ST_ORD;
                w_t_n     = '0;
                if (ofifo_valid) begin
                    w_ord_rd  = 1'b1;
                    w_ord_idx = '0;
                    w_t_n     = c_T_ONE;
                end
            end
            c_ST_ORD: begin
                if (r_t == c_ORD_CNT) begin
                    w_t_n = '0;
                    if (r_kij == c_KIJ_LAST) begin
                        w_state_n = c_ST_DONE;
                    end else begin
                        w_state_n = c_ST_WAIT_W;
                        w_kij_n   = r_kij + 4'd1;
                    end
                end else if (ofifo_valid) begin
                    w_ord_rd  = 1'b1;
                    w_ord_idx = r_t;
                    w_t_n     = r_t + c_T_ONE;
                end
            end
            c_ST_DONE: begin
                w_state_n = c_ST_IDLE;
                w_t_n     = '0;
            end
            default: begin
                w_state_n = c_ST_IDLE;
                w_t_n     = '0;
            end
        endcase
    end

    // pmem row base for the current pass; 11 bits is enough for 36*8+35.
    assign w_pbase = c_NIJ11 * {7'd0, r_kij};

    // ------------------------------------------------------------------------
    // Instruction word for the coming cycle, built from the next state so the
    // registered output lines up with the state register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_inst_n = c_IDLE_WORD;
        case (w_state_n)
            c_ST_WLD: begin
                w_inst_n[c_B_IFIFO_WR] = 1'b1;
                w_inst_n[c_B_CEN_XMEM] = 1'b0;
                w_inst_n[17:7]         = c_WBASE11 + 11'(w_t_n);
            end
            c_ST_PLOAD: begin
                w_inst_n[c_B_IFIFO_RD] = 1'b1;
                w_inst_n[c_B_LOAD]     = 1'b1;
            end
            c_ST_AWR: begin
                w_inst_n[c_B_L0_WR]    = 1'b1;
                w_inst_n[c_B_CEN_XMEM] = 1'b0;
                w_inst_n[17:7]         = 11'(w_t_n);
            end
            c_ST_EXEC: begin
                w_inst_n[c_B_L0_RD]   = 1'b1;
                w_inst_n[c_B_EXECUTE] = 1'b1;
            end
            c_ST_ORD: begin
                if (w_ord_rd) begin
                    w_inst_n[c_B_OFIFO_RD] = 1'b1;
                    w_inst_n[c_B_CEN_PMEM] = 1'b0;
                    w_inst_n[c_B_WEN_PMEM] = 1'b0;
                    w_inst_n[30:20]        = w_pbase + 11'(w_ord_idx);
                end
            end
            default: begin
                w_inst_n = c_IDLE_WORD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_t     <= '0;
            r_kij   <= 4'd0;
            r_inst  <= c_IDLE_WORD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_t     <= w_t_n;
            r_kij   <= w_kij_n;
            r_inst  <= w_inst_n;
            r_busy  <= (w_state_n != c_ST_IDLE) && (w_state_n != c_ST_DONE);
            r_done  <= (w_state_n == c_ST_DONE);
        end
    end

    assign inst = r_inst;
    assign kij  = r_kij;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
